// File: rtl/bht_access_scheduler.sv
// bht_access_scheduler: owner and scheduler of the single-port gshare BHT RAM.
// Arbitrates the post-reset init sweep, fetch lookups (pc ^ GHR) and queued
// resolved-branch counter updates, which retire as read-modify-writes in fetch-idle cycles.
// Optional feature macro: BHT_BYPASS_EN. When defined, WR-phase writes take the port
// ahead of lookups and a lookup hitting the most recent write address is predicted
// from the forwarded write data.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   flush                       sync soft restart (FIFO cleared, GHR=0, init sweep restarts)
//   lu_valid/lu_pc/lu_jump      fetch lookup request; lu_ready = accepted this cycle
//   pred_valid/pred_taken       prediction, one cycle after an accepted lookup
//   upd_valid/upd_pc/upd_taken  resolved branch; upd_ready = FIFO not full
//   drop_cnt                    saturating count of updates lost to a full FIFO
//   bht_en/we/addr/wdata/rdata  RAM port, read data valid the cycle after a read
module bht_access_scheduler #(
  parameter int unsigned      IDX_W    = 8,
  parameter int unsigned      CNT_W    = 2,
  parameter logic [CNT_W-1:0] INIT_VAL = 'b01,
  parameter int unsigned      DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             lu_valid,
  input  logic [IDX_W-1:0] lu_pc,
  input  logic             lu_jump,
  output logic             lu_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_pc,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic [7:0]       drop_cnt,
  output logic             bht_en,
  output logic             bht_we,
  output logic [IDX_W-1:0] bht_addr,
  output logic [CNT_W-1:0] bht_wdata,
  input  logic [CNT_W-1:0] bht_rdata
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;

  state_t           state;
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] sweep_ptr;
  logic [IDX_W-1:0] work_idx;
  logic             work_taken;
  logic             wr_first;   // first WR cycle: bht_rdata holds the RD result
  logic [CNT_W-1:0] cnt_q;
  logic             jump_q;

  // Update FIFO: entry = {gshare index, outcome}; extra pointer bit tells full from empty.
  logic [IDX_W:0]   fifo_mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;

  logic             in_init;
  logic             init_wr;
  logic             lu_fire;
  logic [IDX_W-1:0] lu_idx;
  logic             push;
  logic             drop;
  logic             start_rmw;
  logic             rd_fire;
  logic             wr_fire;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_next;
  logic             pred_bit;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign in_init = (state == S_INIT);
  // Gating with rst_n keeps the port quiet while reset is held.
  assign init_wr = in_init && !flush && rst_n;
  assign lu_idx  = lu_pc ^ ghr;

`ifdef BHT_BYPASS_EN
  assign lu_ready = !flush && !in_init && (state != S_WR);
  assign wr_fire  = (state == S_WR) && !flush;
`else
  assign lu_ready = !flush && !in_init;
  assign wr_fire  = (state == S_WR) && !flush && !lu_valid;
`endif

  assign lu_fire   = lu_valid && lu_ready;
  assign upd_ready = !flush && !in_init && !fifo_full;
  assign push      = upd_valid && upd_ready;
  assign drop      = upd_valid && !upd_ready && !flush && !in_init;
  // Retirement only starts in a fetch-idle cycle, so a held lookup stream freezes the FIFO.
  assign start_rmw = (state == S_IDLE) && !fifo_empty && !flush && !lu_valid;
  assign rd_fire   = (state == S_RD) && !flush && !lu_valid;

  always_comb begin
    cnt_cur  = wr_first ? bht_rdata : cnt_q;
    cnt_next = cnt_cur;
    if (work_taken) begin
      if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + 1'b1;
    end else begin
      if (cnt_cur != '0) cnt_next = cnt_cur - 1'b1;
    end
  end

  // RAM port mux; lookup and WR write are mutually exclusive by construction of wr_fire/lu_ready.
  always_comb begin
    bht_en    = 1'b0;
    bht_we    = 1'b0;
    bht_addr  = '0;
    bht_wdata = '0;
    if (init_wr) begin
      bht_en    = 1'b1;
      bht_we    = 1'b1;
      bht_addr  = sweep_ptr;
      bht_wdata = INIT_VAL;
    end else if (lu_fire) begin
      bht_en   = 1'b1;
      bht_addr = lu_idx;
    end else if (rd_fire) begin
      bht_en   = 1'b1;
      bht_addr = work_idx;
    end else if (wr_fire) begin
      bht_en    = 1'b1;
      bht_we    = 1'b1;
      bht_addr  = work_idx;
      bht_wdata = cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      sweep_ptr  <= '0;
      ghr        <= '0;
      work_idx   <= '0;
      work_taken <= 1'b0;
      wr_first   <= 1'b0;
      cnt_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pred_valid <= 1'b0;
      jump_q     <= 1'b0;
    end else if (flush) begin
      state      <= S_INIT;
      sweep_ptr  <= '0;
      ghr        <= '0;
      wr_first   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pred_valid <= 1'b0;
      jump_q     <= 1'b0;
    end else begin
      pred_valid <= lu_fire;
      jump_q     <= lu_fire && lu_jump;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (upd_valid && !in_init) ghr <= {ghr[IDX_W-2:0], upd_taken};
      case (state)
        S_INIT: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == LAST_IDX) state <= S_IDLE;
        end
        S_IDLE: begin
          if (start_rmw) begin
            {work_idx, work_taken} <= fifo_mem[rd_ptr[PTR_W-1:0]];
            rd_ptr <= rd_ptr + 1'b1;
            state  <= S_RD;
          end
        end
        S_RD: begin
          if (rd_fire) begin
            wr_first <= 1'b1;
            state    <= S_WR;
          end
        end
        S_WR: begin
          wr_first <= 1'b0;
          if (wr_first) cnt_q <= bht_rdata;
          if (wr_fire) state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {upd_pc ^ ghr, upd_taken};
  end

  // Survives flush; only a hard reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef BHT_BYPASS_EN
  logic             fwd_vld;
  logic [IDX_W-1:0] fwd_addr;
  logic [CNT_W-1:0] fwd_dat;
  logic             hit_q;
  logic [CNT_W-1:0] hit_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_vld   <= 1'b0;
      fwd_addr  <= '0;
      fwd_dat   <= '0;
      hit_q     <= 1'b0;
      hit_dat_q <= '0;
    end else if (flush) begin
      fwd_vld <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      if (wr_fire) begin
        fwd_vld  <= 1'b1;
        fwd_addr <= work_idx;
        fwd_dat  <= cnt_next;
      end
      hit_q     <= lu_fire && fwd_vld && (fwd_addr == lu_idx);
      hit_dat_q <= fwd_dat;
    end
  end

  assign pred_bit = hit_q ? hit_dat_q[CNT_W-1] : bht_rdata[CNT_W-1];
`else
  assign pred_bit = bht_rdata[CNT_W-1];
`endif

  assign pred_taken = pred_valid && (pred_bit || jump_q);

endmodule
